// File: rtl/axis64_kvs_pkg.sv
// axis64_kvs_pkg: shared types and widths for the 64-bit stream rx sink.
// Holds the run-state enum, the default timestamp width and byte-count width.
package axis64_kvs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE,
      ST_TMO
   } kvs_state_e;

   localparam int TS_W_DEF = 64;
   localparam int BYTES_W  = 40;

endpackage

// File: rtl/axis64_keep_check.sv
// axis64_keep_check: byte count and tkeep legality for one 64-bit beat.
// In: tkeep[7:0], tlast. Out: nbytes[3:0] popcount, keep_err violation.
module axis64_keep_check (
   input  logic [7:0] tkeep,
   input  logic       tlast,
   output logic [3:0] nbytes,
   output logic       keep_err
);

   logic contig;

   always_comb begin
      nbytes = '0;
      for (int i = 0; i < 8; i++) begin
         nbytes = nbytes + {3'b000, tkeep[i]};
      end
   end

   // 2^n-1 has no set bit above a clear bit: adding one
   // carries through the ones and shares no bit with them.
   always_comb begin
      contig   = ((tkeep & (tkeep + 8'd1)) == 8'd0);
      keep_err = tlast ? ((tkeep == 8'd0) | ~contig)
                       : (tkeep != 8'hFF);
   end

endmodule

// File: rtl/axis64_kvs_rx_sink.sv
// axis64_kvs_rx_sink: 64-bit stream sink measuring one run of packets.
// Ports: clk_390/sys_rst; enable, stall, nr_expected; to_net_* stream in,
// to_net_tready out; nr_pkts..cycle_count stats; done/timeout/proto_err.
module axis64_kvs_rx_sink
   import axis64_kvs_pkg::*;
#(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
   parameter int          TS_W           = TS_W_DEF
) (
   input  logic               clk_390,
   input  logic               sys_rst,
   input  logic               enable,
   input  logic               stall,
   input  logic [31:0]        nr_expected,
   input  logic [63:0]        to_net_tdata,
   input  logic [7:0]         to_net_tkeep,
   input  logic [63:0]        to_net_tuser,
   input  logic               to_net_tlast,
   input  logic               to_net_tvalid,
   output logic               to_net_tready,
   output logic [31:0]        nr_pkts,
   output logic [31:0]        nr_beats,
   output logic [BYTES_W-1:0] nr_bytes,
   output logic [63:0]        checksum,
   output logic [TS_W-1:0]    first_rx_cycle,
   output logic [TS_W-1:0]    last_rx_cycle,
   output logic [TS_W-1:0]    cycle_count,
   output logic               done,
   output logic               timeout,
   output logic               proto_err
);

   kvs_state_e  state;
   kvs_state_e  nxt;
   logic [31:0] exp_q;
   logic [31:0] idle_q;
   logic        seen_q;
   logic        hs;
   logic        start;
   logic        done_hit;
   logic        tmo_hit;
   logic [3:0]  keep_nbytes;
   logic        keep_err;
   logic        unused_tuser;

   assign unused_tuser = ^to_net_tuser;

   axis64_keep_check u_keep (
      .tkeep    (to_net_tkeep),
      .tlast    (to_net_tlast),
      .nbytes   (keep_nbytes),
      .keep_err (keep_err)
   );

   assign hs       = to_net_tvalid & to_net_tready;
   assign start    = (state == ST_IDLE) & enable;
   assign done_hit = (nr_pkts == exp_q);
   // Leave on the edge that closes the last allowed idle cycle.
   assign tmo_hit  = ~hs & (idle_q == TIMEOUT_CYCLES - 32'd1);

   always_ff @(posedge clk_390) begin
      if (sys_rst) begin
         state   <= ST_IDLE;
         done    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= nxt;
         done    <= (nxt == ST_DONE);
         timeout <= (nxt == ST_TMO);
      end
   end

   always_comb begin
      nxt = state;
      unique case (1'b1)
         (state == ST_IDLE): begin
            if (enable) nxt = ST_RUN;
         end
         (state == ST_RUN): begin
            if (done_hit)     nxt = ST_DONE;
            else if (tmo_hit) nxt = ST_TMO;
         end
         default: begin
            if (!enable) nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      to_net_tready = (state == ST_RUN) & ~stall;
   end

   always_ff @(posedge clk_390) begin
      if (sys_rst || start) begin
         exp_q          <= sys_rst ? '0 : nr_expected;
         idle_q         <= '0;
         seen_q         <= 1'b0;
         nr_pkts        <= '0;
         nr_beats       <= '0;
         nr_bytes       <= '0;
         checksum       <= '0;
         first_rx_cycle <= '0;
         last_rx_cycle  <= '0;
         cycle_count    <= '0;
         proto_err      <= 1'b0;
      end else if (state == ST_RUN) begin
         cycle_count <= cycle_count + TS_W'(1);
         idle_q      <= hs ? '0 : idle_q + 32'd1;
         if (hs) begin
            if (~&nr_beats) nr_beats <= nr_beats + 32'd1;
            nr_bytes <= nr_bytes
                      + {{(BYTES_W-4){1'b0}}, keep_nbytes};
            checksum <= checksum ^ to_net_tdata;
            if (!seen_q) begin
               first_rx_cycle <= cycle_count;
               seen_q         <= 1'b1;
            end
            if (keep_err) proto_err <= 1'b1;
            if (to_net_tlast) begin
               if (~&nr_pkts) nr_pkts <= nr_pkts + 32'd1;
               last_rx_cycle <= cycle_count;
            end
         end
      end
   end

endmodule
